// File: rtl/pa_mips_pkg.sv
// Shared types and widths for the commit stage and its store buffer.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package pa_mips_pkg;

    localparam int REG_W = 5;
    localparam int XLEN  = 32;

    // One store-buffer slot: the word address/data pair of a committed store.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/commit_store_buffer_if.sv
// Bundle of ROB retire, register-file write, memory drain and load-probe signals.
// Latency: none; wiring only.
// Backpressure: commit_stall toward the ROB, mem_req/mem_ack toward memory.
interface commit_store_buffer_if;
    import pa_mips_pkg::*;

    // ROB retire port
    logic             rob_we;
    logic             rob_store;
    logic [REG_W-1:0] rob_rd;
    logic [XLEN-1:0]  rob_val;
    logic [XLEN-1:0]  rob_addr;
    logic             commit_stall;

    // Register-file write port
    logic             rf_we;
    logic [REG_W-1:0] rf_rd;
    logic [XLEN-1:0]  rf_val;

    // Data-memory drain port
    logic             mem_req;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic             mem_ack;

    // Load-unit forwarding probe and buffer status
    logic [XLEN-1:0]  ld_addr;
    logic             ld_hit;
    logic [XLEN-1:0]  ld_data;
    logic             sb_empty;

    // Commit-stage view
    modport slave (
        input  rob_we, rob_store, rob_rd, rob_val, rob_addr, mem_ack, ld_addr,
        output commit_stall, rf_we, rf_rd, rf_val, mem_req, mem_addr, mem_wdata,
               ld_hit, ld_data, sb_empty
    );

    // Surrounding pipeline / memory view
    modport master (
        output rob_we, rob_store, rob_rd, rob_val, rob_addr, mem_ack, ld_addr,
        input  commit_stall, rf_we, rf_rd, rf_val, mem_req, mem_addr, mem_wdata,
               ld_hit, ld_data, sb_empty
    );

endinterface

// File: rtl/sb_forward.sv
// Youngest-match word search of the store buffer for a load address.
// Latency: purely combinational.
// Backpressure: none; answers every probe in the same cycle.
module sb_forward
    import pa_mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t        entries [DEPTH],
    input  logic [PTR_W-1:0] head,
    input  logic [XLEN-1:0]  ld_addr,
    output logic             ld_hit,
    output logic [XLEN-1:0]  ld_data
);

    // Byte offset is ignored: a word hit forwards the whole stored word.
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest from head so the last (youngest) hit overrides.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (entries[idx].valid &&
                ((entries[idx].addr & WORD_MASK) == (ld_addr & WORD_MASK))) begin
                ld_hit  = 1'b1;
                ld_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/commit_store_buffer.sv
// Retires ROB head: registered RF write, committed stores queued and drained to memory.
// Latency: RF write 1 cycle; a store reaches mem_req 2 cycles after commit into an idle buffer.
// Backpressure: commit_stall while full (no same-cycle pop credit); mem_req held until mem_ack.
module commit_store_buffer
    import pa_mips_pkg::*;
#(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int PTR_W = $clog2(DEPTH)
) (
    input logic                   clk,
    input logic                   rst,
    commit_store_buffer_if.slave  bus
);

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_nxt;
    logic [PTR_W:0]   count;
    logic             full;
    logic             push;
    logic             pop;

    logic             rf_we_q;
    logic [REG_W-1:0] rf_rd_q;
    logic [XLEN-1:0]  rf_val_q;
    logic             mem_req_q;
    logic [XLEN-1:0]  mem_addr_q;
    logic [XLEN-1:0]  mem_wdata_q;

    // Full is judged on current occupancy only, so an ack this cycle does not free a slot.
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign push     = bus.rob_we && bus.rob_store && !full;
    assign pop      = mem_req_q && bus.mem_ack;
    assign head_nxt = head + PTR_W'(1);

    assign bus.commit_stall = bus.rob_we && bus.rob_store && full;
    assign bus.sb_empty     = (count == '0);
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_rd        = rf_rd_q;
    assign bus.rf_val       = rf_val_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;

    // Register results: one-cycle write pulse; writes to r0 are suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q  <= 1'b0;
            rf_rd_q  <= '0;
            rf_val_q <= '0;
        end else begin
            rf_we_q <= bus.rob_we && !bus.rob_store && (bus.rob_rd != '0);
            if (bus.rob_we && !bus.rob_store) begin
                rf_rd_q  <= bus.rob_rd;
                rf_val_q <= bus.rob_val;
            end
        end
    end

    // Entry array: fill at tail on commit, retire head on memory ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[tail] <= '{valid: 1'b1, addr: bus.rob_addr, data: bus.rob_val};
            end
            if (pop) begin
                entries[head].valid <= 1'b0;
            end
        end
    end

    // Pointers wrap modulo DEPTH; occupancy is tracked separately to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head_nxt;
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Drain: request the head, hold until acked, then chain straight to the next entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (!mem_req_q) begin
            if (count != '0) begin
                mem_req_q   <= 1'b1;
                mem_addr_q  <= entries[head].addr;
                mem_wdata_q <= entries[head].data;
            end
        end else if (bus.mem_ack) begin
            if (count > (PTR_W+1)'(1)) begin
                mem_addr_q  <= entries[head_nxt].addr;
                mem_wdata_q <= entries[head_nxt].data;
            end else begin
                mem_req_q <= 1'b0;
            end
        end
    end

    // Load-unit forwarding over the live entries.
    sb_forward #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_sb_forward (
        .entries (entries),
        .head    (head),
        .ld_addr (bus.ld_addr),
        .ld_hit  (bus.ld_hit),
        .ld_data (bus.ld_data)
    );

endmodule

// File: tb/tb_commit_store_buffer.sv
// Directed bench for commit_store_buffer: RF commit, store queue, stall, forwarding, drain, reset.
// Latency: inputs driven 1ns after the rising edge, outputs sampled in the same window.
// Backpressure: exercises commit_stall and a held/tied mem_ack.
module tb_commit_store_buffer;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    commit_store_buffer_if bus ();

    commit_store_buffer #(
        .DEPTH (4),
        .PTR_W (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_rob();
        bus.rob_we    = 1'b0;
        bus.rob_store = 1'b0;
        bus.rob_rd    = '0;
        bus.rob_val   = '0;
        bus.rob_addr  = '0;
    endtask

    task automatic put_store(input logic [31:0] a, input logic [31:0] d);
        bus.rob_we    = 1'b1;
        bus.rob_store = 1'b1;
        bus.rob_rd    = '0;
        bus.rob_addr  = a;
        bus.rob_val   = d;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        idle_rob();
        bus.mem_ack = 1'b0;
        bus.ld_addr = '0;
        #12;
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we: got %0h want 0", bus.rf_we); end
        total++; if (bus.rf_val !== 32'h0) begin bad++; $display("FAIL reset_rf_val: got %0h want 0", bus.rf_val); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %0h want 0", bus.mem_req); end
        total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %0h want 0", bus.mem_addr); end
        total++; if (bus.sb_empty !== 1'b1) begin bad++; $display("FAIL reset_sb_empty: got %0h want 1", bus.sb_empty); end
        total++; if (bus.ld_hit !== 1'b0) begin bad++; $display("FAIL reset_ld_hit: got %0h want 0", bus.ld_hit); end
        total++; if (bus.commit_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0h want 0", bus.commit_stall); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_reg_commit();
        bus.rob_we = 1'b1; bus.rob_store = 1'b0; bus.rob_rd = 5'd5; bus.rob_val = 32'hDEADBEEF;
        step();
        idle_rob();
        total++; if (bus.rf_we !== 1'b1) begin bad++; $display("FAIL reg_rf_we: got %0h want 1", bus.rf_we); end
        total++; if (bus.rf_rd !== 5'd5) begin bad++; $display("FAIL reg_rf_rd: got %0d want 5", bus.rf_rd); end
        total++; if (bus.rf_val !== 32'hDEADBEEF) begin bad++; $display("FAIL reg_rf_val: got %0h want deadbeef", bus.rf_val); end
        total++; if (bus.sb_empty !== 1'b1) begin bad++; $display("FAIL reg_sb_empty: got %0h want 1", bus.sb_empty); end
        step();
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reg_pulse: got %0h want 0", bus.rf_we); end
        bus.rob_we = 1'b1; bus.rob_store = 1'b0; bus.rob_rd = 5'd0; bus.rob_val = 32'h12345678;
        step();
        idle_rob();
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reg_r0_we: got %0h want 0", bus.rf_we); end
    endtask

    task automatic test_single_store();
        bus.mem_ack = 1'b0;
        bus.rob_we = 1'b1; bus.rob_store = 1'b0; bus.rob_rd = 5'd7; bus.rob_val = 32'h77;
        step();
        total++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7) begin bad++; $display("FAIL st_pre_rf: got we=%0h rd=%0d want we=1 rd=7", bus.rf_we, bus.rf_rd); end
        put_store(32'h100, 32'h11);
        #1;
        total++; if (bus.commit_stall !== 1'b0) begin bad++; $display("FAIL st_stall: got %0h want 0", bus.commit_stall); end
        step();
        idle_rob();
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL st_rf_we: got %0h want 0", bus.rf_we); end
        total++; if (bus.sb_empty !== 1'b0) begin bad++; $display("FAIL st_not_empty: got %0h want 0", bus.sb_empty); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL st_req_early: got %0h want 0", bus.mem_req); end
        bus.ld_addr = 32'h100;
        #1;
        total++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'h11) begin bad++; $display("FAIL st_fwd: got hit=%0h data=%0h want hit=1 data=11", bus.ld_hit, bus.ld_data); end
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'h11) begin
                bad++;
                $display("FAIL st_hold%0d: got req=%0h addr=%0h data=%0h want 1/100/11", k, bus.mem_req, bus.mem_addr, bus.mem_wdata);
            end
        end
        bus.mem_ack = 1'b1;
        #1;
        total++; if (bus.ld_hit !== 1'b1) begin bad++; $display("FAIL st_fwd_acking: got %0h want 1", bus.ld_hit); end
        step();
        bus.mem_ack = 1'b0;
        #1;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL st_req_drop: got %0h want 0", bus.mem_req); end
        total++; if (bus.sb_empty !== 1'b1) begin bad++; $display("FAIL st_empty: got %0h want 1", bus.sb_empty); end
        total++; if (bus.ld_hit !== 1'b0) begin bad++; $display("FAIL st_fwd_gone: got %0h want 0", bus.ld_hit); end
    endtask

    task automatic test_fill_stall();
        logic [31:0] ea;
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put_store(32'h300 + 32'(4 * i), 32'h30 + 32'(i));
            #1;
            total++; if (bus.commit_stall !== 1'b0) begin bad++; $display("FAIL fill_stall%0d: got %0h want 0", i, bus.commit_stall); end
            step();
        end
        put_store(32'h310, 32'h34);
        #1;
        total++; if (bus.commit_stall !== 1'b1) begin bad++; $display("FAIL fill_full_stall: got %0h want 1", bus.commit_stall); end
        total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300) begin bad++; $display("FAIL fill_req0: got req=%0h addr=%0h want 1/300", bus.mem_req, bus.mem_addr); end
        bus.mem_ack = 1'b1;
        #1;
        total++; if (bus.commit_stall !== 1'b1) begin bad++; $display("FAIL fill_stall_with_ack: got %0h want 1", bus.commit_stall); end
        step();
        bus.mem_ack = 1'b0;
        #1;
        total++; if (bus.commit_stall !== 1'b0) begin bad++; $display("FAIL fill_stall_clear: got %0h want 0", bus.commit_stall); end
        total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h304 || bus.mem_wdata !== 32'h31) begin bad++; $display("FAIL fill_advance: got req=%0h addr=%0h data=%0h want 1/304/31", bus.mem_req, bus.mem_addr, bus.mem_wdata); end
        step();
        put_store(32'h320, 32'h99);
        #1;
        total++; if (bus.commit_stall !== 1'b1) begin bad++; $display("FAIL fill_refull: got %0h want 1", bus.commit_stall); end
        idle_rob();
        bus.ld_addr = 32'h310;
        #1;
        total++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'h34) begin bad++; $display("FAIL fill_fwd5: got hit=%0h data=%0h want 1/34", bus.ld_hit, bus.ld_data); end
        bus.mem_ack = 1'b1;
        for (int i = 1; i < 5; i++) begin
            ea = 32'h300 + 32'(4 * i);
            total++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== ea || bus.mem_wdata !== 32'h30 + 32'(i)) begin
                bad++;
                $display("FAIL fill_drain%0d: got req=%0h addr=%0h data=%0h want 1/%0h/%0h", i, bus.mem_req, bus.mem_addr, bus.mem_wdata, ea, 32'h30 + 32'(i));
            end
            step();
        end
        bus.mem_ack = 1'b0;
        #1;
        total++; if (bus.sb_empty !== 1'b1 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL fill_drained: got empty=%0h req=%0h want 1/0", bus.sb_empty, bus.mem_req); end
    endtask

    task automatic test_forwarding();
        bus.mem_ack = 1'b0;
        put_store(32'h200, 32'hA);
        step();
        put_store(32'h200, 32'hB);
        step();
        idle_rob();
        bus.ld_addr = 32'h202;
        #1;
        total++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'hB) begin bad++; $display("FAIL fwd_young: got hit=%0h data=%0h want 1/b", bus.ld_hit, bus.ld_data); end
        bus.ld_addr = 32'h204;
        #1;
        total++; if (bus.ld_hit !== 1'b0 || bus.ld_data !== 32'h0) begin bad++; $display("FAIL fwd_miss: got hit=%0h data=%0h want 0/0", bus.ld_hit, bus.ld_data); end
        bus.ld_addr = 32'h1FC;
        #1;
        total++; if (bus.ld_hit !== 1'b0) begin bad++; $display("FAIL fwd_miss_below: got %0h want 0", bus.ld_hit); end
        bus.ld_addr = 32'h200;
        bus.mem_ack = 1'b1;
        step();
        total++; if (bus.mem_addr !== 32'h200 || bus.mem_wdata !== 32'hB) begin bad++; $display("FAIL fwd_req_b: got addr=%0h data=%0h want 200/b", bus.mem_addr, bus.mem_wdata); end
        total++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'hB) begin bad++; $display("FAIL fwd_acking: got hit=%0h data=%0h want 1/b", bus.ld_hit, bus.ld_data); end
        step();
        bus.mem_ack = 1'b0;
        #1;
        total++; if (bus.ld_hit !== 1'b0 || bus.sb_empty !== 1'b1) begin bad++; $display("FAIL fwd_drained: got hit=%0h empty=%0h want 0/1", bus.ld_hit, bus.sb_empty); end
    endtask

    task automatic test_back_to_back();
        int          drained = 0;
        bit          seen    = 1'b0;
        logic [31:0] ea;
        logic [31:0] ed;
        bus.mem_ack = 1'b1;
        for (int c = 0; c < 20 && drained < 10; c++) begin
            if (c < 10) begin
                put_store(32'h400 + 32'(4 * c), 32'h1000 + 32'(c));
                total++; if (bus.commit_stall !== 1'b0) begin bad++; $display("FAIL b2b_stall%0d: got %0h want 0", c, bus.commit_stall); end
            end else begin
                idle_rob();
            end
            if (bus.mem_req === 1'b1) begin
                seen = 1'b1;
                ea   = 32'h400 + 32'(4 * drained);
                ed   = 32'h1000 + 32'(drained);
                total++;
                if (bus.mem_addr !== ea || bus.mem_wdata !== ed) begin
                    bad++;
                    $display("FAIL b2b_order%0d: got addr=%0h data=%0h want %0h/%0h", drained, bus.mem_addr, bus.mem_wdata, ea, ed);
                end
                drained++;
            end else if (seen) begin
                total++; bad++;
                $display("FAIL b2b_bubble: got req=0 at cycle %0d want 1", c);
            end
            step();
        end
        idle_rob();
        bus.mem_ack = 1'b0;
        #1;
        total++; if (drained != 10) begin bad++; $display("FAIL b2b_count: got %0d want 10", drained); end
        total++; if (bus.sb_empty !== 1'b1 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL b2b_end: got empty=%0h req=%0h want 1/0", bus.sb_empty, bus.mem_req); end
    endtask

    task automatic test_reset_mid();
        bus.mem_ack = 1'b0;
        put_store(32'h500, 32'h55);
        step();
        put_store(32'h504, 32'h56);
        step();
        idle_rob();
        step();
        total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h500) begin bad++; $display("FAIL rst_pre_req: got req=%0h addr=%0h want 1/500", bus.mem_req, bus.mem_addr); end
        #2;
        rst         = 1'b1;
        bus.ld_addr = 32'h500;
        #1;
        total++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_async_mem: got req=%0h addr=%0h data=%0h want 0/0/0", bus.mem_req, bus.mem_addr, bus.mem_wdata); end
        total++; if (bus.sb_empty !== 1'b1) begin bad++; $display("FAIL rst_async_empty: got %0h want 1", bus.sb_empty); end
        total++; if (bus.ld_hit !== 1'b0) begin bad++; $display("FAIL rst_async_fwd: got %0h want 0", bus.ld_hit); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (bus.mem_req !== 1'b0 || bus.sb_empty !== 1'b1) begin
                bad++;
                $display("FAIL rst_no_reissue%0d: got req=%0h empty=%0h want 0/1", k, bus.mem_req, bus.sb_empty);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reg_commit();
        test_single_store();
        test_fill_stall();
        test_forwarding();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
